regfile_bypass_ctrl: RTL and testbench
======================================

REGFILE_BYPASS_CTRL -- requirements
Module: regfile_bypass_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5; the file depth is 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports; the legal range is 1..4.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports id_valid  input  1  and rd_use  input  NUM_RD; these flag a valid ID instruction and the read ports it uses.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses, with port 0 in the LSBs.
REQ-008 SHALL have ports ex_wr_en/ex_is_load (input 1 each), ex_wr_addr (input ADDR_W) and ex_wr_data (input DATA_W); these describe the instruction currently in EX.
REQ-009 SHALL have ports mem_wr_en (input 1), mem_wr_addr (input ADDR_W) and mem_wr_data (input DATA_W); these describe the instruction in MEM, carrying the load data where applicable.
REQ-010 SHALL have ports wb_wr_en (input 1), wb_wr_addr (input ADDR_W) and wb_wr_data (input DATA_W); this is the commit port into the register file.
REQ-011 SHALL have port flush  input  1  which squashes the ID instruction.
REQ-012 SHALL have port stall  output  1  the combinational hold request to IF/ID.
REQ-013 SHALL have ports ex_op_data (output NUM_RD*DATA_W, registered) and ex_op_valid (output 1, registered); these are the resolved operands for ID/EX.
REQ-014 SHALL have port stall_cnt  output  16  which counts stall cycles.

Function
REQ-015 SHALL hold 2**ADDR_W registers; entry 0 SHALL read as 0, writes to entry 0 SHALL be ignored, and entry 0 SHALL never forward or cause a stall.
REQ-016 SHALL write wb_wr_data to wb_wr_addr on a rising edge when wb_wr_en=1.
REQ-017 SHALL resolve each read port j by this priority, youngest first: EX match (ex_wr_en, non-load) > MEM match > WB match (write-through) > file contents.
REQ-018 SHALL assert stall when id_valid=1, rd_use[j]=1, ex_wr_en=1, ex_is_load=1 and ex_wr_addr=rd_addr[j]!=0 for any port j (load-use).
REQ-019 SHALL, on an edge with id_valid=1, stall=0 and flush=0, load ex_op_data with the resolved values and set ex_op_valid=1 (1-cycle latency).
REQ-020 SHALL otherwise clear ex_op_valid to 0 (bubble) and hold ex_op_data.
REQ-021 SHALL give flush priority over stall; with flush=1, stall SHALL be forced to 0.
REQ-022 SHALL leave ports with rd_use[j]=0 excluded from stall, while still updating their data.
REQ-023 SHALL increment stall_cnt by 1 on every edge where stall=1, saturating at 16'hFFFF with no wrap-around.
REQ-024 SHALL ignore X/garbage on the data inputs when the associated enable is 0.

Reset
REQ-025 SHALL, while RESET=1, immediately clear all file entries, ex_op_data and stall_cnt to 0, clear ex_op_valid to 0, and force stall to 0.
REQ-026 SHALL, when reset is asserted mid-stall, drop stall immediately; the first post-reset edge SHALL behave as a normal cycle.

Configuration
REQ-027 SHALL, when macro REGFILE_BYPASS_FWD_EN is defined, implement the EX/MEM bypasses of REQ-017 and the load-use-only stall of REQ-018.
REQ-028 SHALL, when REGFILE_BYPASS_FWD_EN is undefined, remove the EX/MEM bypasses and assert stall on any used-port address match with a valid EX or MEM write; WB write-through SHALL remain in both builds.

Verification
REQ-029 SHALL cover: wb write r5=0x1234 with a same-cycle read of r5 -> next edge ex_op_data port0=0x1234, ex_op_valid=1.
REQ-030 SHALL cover: EX r3=0xA (ALU), MEM r3=0xB, WB r3=0xC, read r3 -> 0xA under FWD_EN; without FWD_EN -> stall=1 and ex_op_valid=0.
REQ-031 SHALL cover: EX load to r7 with port1 reading r7 and rd_use=2'b10 -> stall=1, bubble, stall_cnt=1; next cycle MEM r7=0x55 -> port1=0x55.
REQ-032 SHALL cover: write r0=0xFFFF, then read r0 with EX load to r0 -> data=0 and stall=0.
REQ-033 SHALL cover: hold the load-use hazard for 70000 cycles -> stall_cnt=16'hFFFF; assert RESET -> stall_cnt=0 and stall=0 with no clock edge.
REQ-034 SHALL cover: flush=1 together with a load-use hazard -> stall=0 and ex_op_valid=0 after the edge.

Source files
------------

// File: rtl/regfile_bypass_ctrl.sv
// Register file with operand bypass resolution and hazard stall for the ID stage.
// Define REGFILE_BYPASS_FWD_EN for EX/MEM forwarding and load-use-only stalls.
module regfile_bypass_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       id_valid,
    input  logic [NUM_RD-1:0]          rd_use,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic                       ex_wr_en,
    input  logic                       ex_is_load,
    input  logic [ADDR_W-1:0]          ex_wr_addr,
    input  logic [DATA_W-1:0]          ex_wr_data,
    input  logic                       mem_wr_en,
    input  logic [ADDR_W-1:0]          mem_wr_addr,
    input  logic [DATA_W-1:0]          mem_wr_data,
    input  logic                       wb_wr_en,
    input  logic [ADDR_W-1:0]          wb_wr_addr,
    input  logic [DATA_W-1:0]          wb_wr_data,
    input  logic                       flush,
    output logic                       stall,
    output logic [NUM_RD*DATA_W-1:0]   ex_op_data,
    output logic                       ex_op_valid,
    output logic [15:0]                stall_cnt
);

    localparam int unsigned Depth  = 2 ** ADDR_W;
    localparam logic [15:0] CntMax = 16'hFFFF;

    logic [DATA_W-1:0]        rf_q [Depth];
    logic [DATA_W-1:0]        rf_d [Depth];
    logic [DATA_W-1:0]        rd_data [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] ex_op_data_q, ex_op_data_d;
    logic                     ex_op_valid_q, ex_op_valid_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;
    logic                     hazard;
    logic [ADDR_W-1:0]        addr;

`ifndef REGFILE_BYPASS_FWD_EN
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_is_load, ex_wr_data, mem_wr_data};
`endif

    always_comb begin
        rf_d = rf_q;
        if (wb_wr_en && (wb_wr_addr != '0)) begin
            rf_d[wb_wr_addr] = wb_wr_data;
        end
    end

    // Sources are applied oldest first so the youngest matching writer wins.
    always_comb begin
        hazard = 1'b0;
        addr   = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            addr       = rd_addr[j*ADDR_W +: ADDR_W];
            rd_data[j] = rf_q[addr];
            if (wb_wr_en && (wb_wr_addr == addr)) begin
                rd_data[j] = wb_wr_data;
            end
`ifdef REGFILE_BYPASS_FWD_EN
            if (mem_wr_en && (mem_wr_addr == addr)) begin
                rd_data[j] = mem_wr_data;
            end
            if (ex_wr_en && !ex_is_load && (ex_wr_addr == addr)) begin
                rd_data[j] = ex_wr_data;
            end
            if (rd_use[j] && (addr != '0) && ex_wr_en && ex_is_load && (ex_wr_addr == addr)) begin
                hazard = 1'b1;
            end
`else
            if (rd_use[j] && (addr != '0) &&
                ((ex_wr_en && (ex_wr_addr == addr)) || (mem_wr_en && (mem_wr_addr == addr)))) begin
                hazard = 1'b1;
            end
`endif
            if (addr == '0) begin
                rd_data[j] = '0;
            end
        end
    end

    assign stall = id_valid & hazard & ~flush & ~RESET;

    always_comb begin
        ex_op_valid_d = id_valid & ~stall & ~flush;
        ex_op_data_d  = ex_op_data_q;
        if (ex_op_valid_d) begin
            for (int j = 0; j < NUM_RD; j++) begin
                ex_op_data_d[j*DATA_W +: DATA_W] = rd_data[j];
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < Depth; i++) begin
                rf_q[i] <= '0;
            end
            ex_op_data_q  <= '0;
            ex_op_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            rf_q          <= rf_d;
            ex_op_data_q  <= ex_op_data_d;
            ex_op_valid_q <= ex_op_valid_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_op_data  = ex_op_data_q;
    assign ex_op_valid = ex_op_valid_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_regfile_bypass_ctrl.sv
// Directed testbench for regfile_bypass_ctrl; expectations follow the build's
// REGFILE_BYPASS_FWD_EN setting.
module tb_regfile_bypass_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [1:0]  rd_use;
    logic [9:0]  rd_addr;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        mem_wr_en;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;
    logic        flush;
    logic        stall;
    logic [63:0] ex_op_data;
    logic        ex_op_valid;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    regfile_bypass_ctrl dut (
        .CLK        (clk),
        .RESET      (rst),
        .id_valid   (id_valid),
        .rd_use     (rd_use),
        .rd_addr    (rd_addr),
        .ex_wr_en   (ex_wr_en),
        .ex_is_load (ex_is_load),
        .ex_wr_addr (ex_wr_addr),
        .ex_wr_data (ex_wr_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .wb_wr_en   (wb_wr_en),
        .wb_wr_addr (wb_wr_addr),
        .wb_wr_data (wb_wr_data),
        .flush      (flush),
        .stall      (stall),
        .ex_op_data (ex_op_data),
        .ex_op_valid(ex_op_valid),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; rd_use = 0; rd_addr = 0; flush = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_wr_data = 32'hBAD0_BAD0;
        mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 32'hBAD1_BAD1;
        wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 32'hBAD2_BAD2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_wr_en = 1; wb_wr_addr = a; wb_wr_data = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        id_valid = 1; rd_use = 2'b10; rd_addr = {5'd7, 5'd0};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd7;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        tick(); tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_op_valid); end
        checks++; if (ex_op_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ex_op_data); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", stall_cnt); end
        @(negedge clk);
        rst = 0;
        idle();
        #1;
    endtask

    task automatic test_write_through();
        idle();
        id_valid = 1; rd_use = 2'b01; rd_addr = {5'd0, 5'd5};
        wb_wr_en = 1; wb_wr_addr = 5'd5; wb_wr_data = 32'h1234;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wt_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_data[31:0] !== 32'h1234) begin errors++; $display("FAIL wt_data got %h exp 1234", ex_op_data[31:0]); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL wt_valid got %0b exp 1", ex_op_valid); end
        idle();
        tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0b exp 0", ex_op_valid); end
        checks++; if (ex_op_data[31:0] !== 32'h1234) begin errors++; $display("FAIL bubble_hold got %h exp 1234", ex_op_data[31:0]); end
    endtask

    task automatic test_priority();
        idle();
        id_valid = 1; rd_use = 2'b01; rd_addr = {5'd0, 5'd3};
        ex_wr_en = 1; ex_wr_addr = 5'd3; ex_wr_data = 32'hA;
        mem_wr_en = 1; mem_wr_addr = 5'd3; mem_wr_data = 32'hB;
        wb_wr_en = 1; wb_wr_addr = 5'd3; wb_wr_data = 32'hC;
        #1;
`ifdef REGFILE_BYPASS_FWD_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_data[31:0] !== 32'hA) begin errors++; $display("FAIL prio_ex got %h exp a", ex_op_data[31:0]); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %0b exp 1", ex_op_valid); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio_stall got %0b exp 1", stall); end
        tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL prio_valid got %0b exp 0", ex_op_valid); end
`endif
        ex_wr_en = 0;
        wb_wr_data = 32'hD;
        #1;
`ifdef REGFILE_BYPASS_FWD_EN
        tick();
        checks++; if (ex_op_data[31:0] !== 32'hB) begin errors++; $display("FAIL prio_mem got %h exp b", ex_op_data[31:0]); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio_mem_stall got %0b exp 1", stall); end
        tick();
`endif
        mem_wr_en = 0; wb_wr_en = 0;
        tick();
        checks++; if (ex_op_data[31:0] !== 32'hD) begin errors++; $display("FAIL prio_file got %h exp d", ex_op_data[31:0]); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL prio_file_valid got %0b exp 1", ex_op_valid); end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        rst = 1; #1; rst = 0; #1;
        wb_write(5'd3, 32'h33);
        wb_write(5'd7, 32'h77);
        id_valid = 1; rd_use = 2'b10; rd_addr = {5'd7, 5'd3};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd7; ex_wr_data = 32'hDEAD;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
        tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b exp 0", ex_op_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_wr_addr = 5'd7; mem_wr_data = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_FWD_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_mem_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_data !== {32'h55, 32'h33}) begin errors++; $display("FAIL lu_mem_data got %h exp 55/33", ex_op_data); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL lu_mem_valid got %0b exp 1", ex_op_valid); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_mem_stall got %0b exp 1", stall); end
        tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL lu_mem_valid got %0b exp 0", ex_op_valid); end
`endif
        mem_wr_en = 0;
        wb_wr_en = 1; wb_wr_addr = 5'd7; wb_wr_data = 32'h55;
        tick();
        checks++; if (ex_op_data !== {32'h55, 32'h33}) begin errors++; $display("FAIL lu_wb_data got %h exp 55/33", ex_op_data); end
`ifdef REGFILE_BYPASS_FWD_EN
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_wb_cnt got %0d exp 1", stall_cnt); end
`else
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_wb_cnt got %0d exp 2", stall_cnt); end
`endif
        idle();
    endtask

    task automatic test_unused_port();
        idle();
        id_valid = 1; rd_use = 2'b01; rd_addr = {5'd7, 5'd3};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd7; ex_wr_data = 32'hDEAD;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_data !== {32'h55, 32'h33}) begin errors++; $display("FAIL unused_data got %h exp 55/33", ex_op_data); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL unused_valid got %0b exp 1", ex_op_valid); end
        idle();
    endtask

    task automatic test_r0();
        wb_write(5'd0, 32'hFFFF);
        id_valid = 1; rd_use = 2'b11; rd_addr = {5'd0, 5'd0};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd0; ex_wr_data = 32'hEEEE;
        mem_wr_en = 1; mem_wr_addr = 5'd0; mem_wr_data = 32'h99;
        wb_wr_en = 1; wb_wr_addr = 5'd0; wb_wr_data = 32'hFFFF;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_data !== 64'h0) begin errors++; $display("FAIL r0_data got %h exp 0", ex_op_data); end
        checks++; if (ex_op_valid !== 1'b1) begin errors++; $display("FAIL r0_valid got %0b exp 1", ex_op_valid); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        id_valid = 1; rd_use = 2'b10; rd_addr = {5'd7, 5'd0}; flush = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd7;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", stall); end
        tick();
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", ex_op_valid); end
`ifdef REGFILE_BYPASS_FWD_EN
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", stall_cnt); end
`else
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", stall_cnt); end
`endif
        idle();
    endtask

    task automatic test_saturation();
        idle();
        id_valid = 1; rd_use = 2'b10; rd_addr = {5'd7, 5'd0};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd7;
        repeat (70000) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h exp ffff", stall_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0b exp 1", stall); end
        checks++; if (ex_op_valid !== 1'b0) begin errors++; $display("FAIL sat_valid got %0b exp 0", ex_op_valid); end
        rst = 1;
        #1;
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", stall_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
        checks++; if (ex_op_data !== 64'h0) begin errors++; $display("FAIL rst_data got %h exp 0", ex_op_data); end
        rst = 0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL post_rst_stall got %0b exp 1", stall); end
        tick();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_cnt got %0d exp 1", stall_cnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_priority();
        test_load_use();
        test_unused_port();
        test_r0();
        test_flush();
        test_saturation();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
